// File: rtl/gray_pkg.sv
// gray_pkg: shared constants and Gray-code helpers for the Gray counter
// and its Gray-to-binary decoder.
//   GRAY_W_DEFAULT : default counter width
//   GRAY_W_MAX     : widest supported count (helpers operate at this width;
//                    narrower values are zero-extended by the caller)
//   bin2gray       : binary -> Gray, g = b ^ (b >> 1)
//   gray2bin       : Gray -> binary, prefix XOR from the MSB down
package gray_pkg;

    localparam int GRAY_W_DEFAULT = 4;
    localparam int GRAY_W_MAX     = 16;

    function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it, so walk
    // down from the MSB carrying the running XOR.
    function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] gray);
        logic [GRAY_W_MAX-1:0] bin;
        bin[GRAY_W_MAX-1] = gray[GRAY_W_MAX-1];
        for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_counter_bin_to_gray.sv
// bin_to_gray: pure combinational binary-to-Gray encoder.
//   bin  : binary input value
//   gray : Gray encoding, gray[W-1] = bin[W-1], gray[i] = bin[i+1] ^ bin[i]
module bin_to_gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// gray_counter: up/down Gray-code counter with parallel binary load.
// Keeps a binary count and registers its Gray encoding on the same edge, so
// every enabled count step changes exactly one bit of g.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; release is synchronised inside
//   en     : count enable
//   up     : 1 = increment, 0 = decrement (used only when en = 1)
//   load   : parallel load strobe, overrides en
//   bin_in : binary value taken on load
//   b      : registered binary count
//   g      : registered Gray encoding of b
//   wrap   : one-cycle pulse after an up-rollover (all-ones -> 0) or a
//            down-rollover (0 -> all-ones)
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] bin_in,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g,
    output logic             wrap
);

    logic [1:0]       sync_q;
    logic             run;
    logic [WIDTH-1:0] next_b;
    logic [WIDTH-1:0] next_g;
    logic             next_wrap;

    // Reset deassertion synchroniser. Assertion clears both stages at once;
    // release shifts a 1 through. The count is allowed from the edge after
    // the first stage sets, so the first load/count lands on the second
    // rising edge after rst_n rises. The second stage keeps the run level
    // once the chain has settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign run = sync_q[0] | sync_q[1];

    // Next-state mux: load > en > hold. wrap is flagged from the current
    // count before it moves, so it lines up with the rollover edge.
    always_comb begin
        next_b    = b;
        next_wrap = 1'b0;
        if (run) begin
            if (load) begin
                next_b = bin_in;
            end else if (en) begin
                if (up) begin
                    next_b    = b + WIDTH'(1);
                    next_wrap = &b;
                end else begin
                    next_b    = b - WIDTH'(1);
                    next_wrap = ~|b;
                end
            end
        end
    end

    bin_to_gray #(
        .WIDTH (WIDTH)
    ) u_bin_to_gray (
        .bin  (next_b),
        .gray (next_g)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b    <= '0;
            g    <= '0;
            wrap <= 1'b0;
        end else begin
            b    <= next_b;
            g    <= next_g;
            wrap <= next_wrap;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed test-plan sequence followed by randomized
// en/up/load traffic, checked against an arithmetic model of the counter.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_gray_counter;
    import gray_pkg::*;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] bin_in;
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         wrap;

    int vectors;
    int miscompares;

    // Reference model state
    int model_b;
    bit model_wrap;
    int rel_edges;     // rising edges seen since rst_n was released
    bit count_step;    // last step was an enabled count (one g bit must flip)
    int prev_gray;     // expected Gray value before the last step

    logic [W-1:0] exp_up_seq [17];

    gray_counter #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .up     (up),
        .load   (load),
        .bin_in (bin_in),
        .b      (b),
        .g      (g),
        .wrap   (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gray_of(input int x);
        return x ^ (x >> 1);
    endfunction

    task automatic check_all(input string tag);
        logic [GRAY_W_MAX-1:0] dec;
        logic [W-1:0]          exp_b;
        logic [W-1:0]          exp_g;
        exp_b = W'(model_b);
        exp_g = W'(gray_of(model_b));
        dec   = gray2bin({{(GRAY_W_MAX-W){1'b0}}, g});

        vectors++;
        assert (b === exp_b) else begin
            miscompares++;
            $error("FAIL %s b: observed %b expected %b", tag, b, exp_b);
        end
        vectors++;
        assert (g === exp_g) else begin
            miscompares++;
            $error("FAIL %s g: observed %b expected %b", tag, g, exp_g);
        end
        vectors++;
        assert (wrap === model_wrap) else begin
            miscompares++;
            $error("FAIL %s wrap: observed %b expected %b", tag, wrap, model_wrap);
        end
        vectors++;
        assert (dec[W-1:0] === exp_b) else begin
            miscompares++;
            $error("FAIL %s decode: observed %b expected %b", tag, dec[W-1:0], exp_b);
        end
        if (count_step) begin
            vectors++;
            assert ($countones(g ^ W'(prev_gray)) == 1) else begin
                miscompares++;
                $error("FAIL %s one_bit: observed g %b from %b expected one bit change",
                       tag, g, W'(prev_gray));
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model on the rising edge and
    // check on the following falling edge.
    task automatic step(input logic l, input logic e, input logic u,
                        input logic [W-1:0] bi, input string tag);
        load      = l;
        en        = e;
        up        = u;
        bin_in    = bi;
        prev_gray = gray_of(model_b);
        @(posedge clk);
        count_step = 1'b0;
        if (rel_edges >= 1) begin
            if (l) begin
                model_b    = int'(bi);
                model_wrap = 1'b0;
            end else if (e) begin
                count_step = 1'b1;
                if (u) begin
                    model_wrap = (model_b + 1 == MOD);
                    model_b    = (model_b + 1) % MOD;
                end else begin
                    model_wrap = (model_b == 0);
                    model_b    = (model_b + MOD - 1) % MOD;
                end
            end else begin
                model_wrap = 1'b0;
            end
        end
        rel_edges++;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic model_reset();
        model_b    = 0;
        model_wrap = 1'b0;
        rel_edges  = 0;
        count_step = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rb;
        exp_up_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                       4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                       4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        up     = 1'b0;
        load   = 1'b0;
        bin_in = '0;
        model_reset();

        // Reset state
        #1;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Count up: first edge after release is absorbed by the synchroniser
        step(1'b0, 1'b1, 1'b1, '0, "up_release");
        vectors++;
        assert (g === exp_up_seq[0]) else begin
            miscompares++;
            $error("FAIL up_seq0: observed %b expected %b", g, exp_up_seq[0]);
        end
        for (int i = 1; i < 17; i++) begin
            step(1'b0, 1'b1, 1'b1, '0, "up");
            vectors++;
            assert (g === exp_up_seq[i]) else begin
                miscompares++;
                $error("FAIL up_seq%0d: observed %b expected %b", i, g, exp_up_seq[i]);
            end
        end

        // Count down from reset
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("down_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0, "down_release");
        step(1'b0, 1'b1, 1'b0, '0, "down_wrap");
        step(1'b0, 1'b1, 1'b0, '0, "down_next");

        // Load, and load winning over en
        step(1'b1, 1'b0, 1'b0, 4'b1010, "load_1010");
        step(1'b1, 1'b1, 1'b1, 4'b1111, "load_over_en");

        // Hold then direction changes
        step(1'b1, 1'b0, 1'b0, 4'b0101, "load_0101");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, '0, "hold");
        step(1'b0, 1'b1, 1'b1, '0, "dir_up1");
        step(1'b0, 1'b1, 1'b1, '0, "dir_up2");
        step(1'b0, 1'b1, 1'b0, '0, "dir_down");

        // Asynchronous reset between edges
        step(1'b1, 1'b0, 1'b0, 4'b1001, "load_1001");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b1, '0, "release_edge1");
        step(1'b0, 1'b1, 1'b1, '0, "release_edge2");

        // Randomized traffic with closed-loop decode
        for (int i = 0; i < 256; i++) begin
            rb = W'($urandom_range(0, MOD - 1));
            step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), rb, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
# gray_counter

Synchronous up/down Gray-code counter with parallel binary load, the encode-side counterpart of the team's Gray-to-binary decoder. It holds a binary count internally and presents both the binary value and its registered Gray encoding, so consumers (pointer exchange, position encoders, decoder benches) see exactly one Gray bit change per count step. It sits wherever a Gray-coded sequence is produced. Paired with the decoder, it forms a closed encode/decode loop.

## Interface
Parameters:
- WIDTH, 4, count width in bits (legal range 2..16)

Ports:
- clk  input  1  single clock, rising-edge active
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement (sampled only when en=1)
- load  input  1  parallel load strobe
- bin_in  input  WIDTH  binary value loaded when load=1
- b  output  WIDTH  registered binary count
- g  output  WIDTH  registered Gray encoding of b
- wrap  output  1  one-cycle pulse: count rolled over on the previous edge

## Operation
- Gray rule: g = b ^ (b >> 1), so g[WIDTH-1] = b[WIDTH-1] and g[i] = b[i+1] ^ b[i].
- Priority each rising edge: load > en > hold.
  - load=1: b <= bin_in, g <= bin2gray(bin_in), wrap <= 0. en and up are ignored.
  - load=0, en=1, up=1: b <= b+1, modulo 2^WIDTH.
  - load=0, en=1, up=0: b <= b-1, modulo 2^WIDTH.
  - load=0, en=0: b, g hold; wrap <= 0.
- wrap <= 1 only on these transitions: up from all-ones to 0, and down from 0 to all-ones. Otherwise wrap <= 0.
- g is computed from next_b and registered on the same edge as b. There is no combinational path from inputs to outputs.
- Invariant on every en-driven step: exactly one bit of g changes, including at wrap. On load, any number of bits may change.
- Direction may change on any cycle with no dead cycle.

## Timing
- Reset (rst_n=0, asynchronous): b=0, g=0, wrap=0 immediately, without waiting for clk.
- Reset is released synchronously inside the block through a 2-flop rst_n deassertion synchroniser. The first count or load takes effect on the second rising edge after rst_n rises.
- Latency: 1 cycle from the sampled en/load to the updated b and g.
- wrap is high for exactly the single cycle following the rollover edge.
- Reset asserted mid-count clears all state. No partial update is retained.

## Structure
- Shared package gray_pkg:
  - constant GRAY_W_DEFAULT = 4
  - function bin2gray(WIDTH-generic)
  - function gray2bin, used by the bench scoreboard
- One natural sub-module: bin_to_gray, a pure combinational WIDTH-parameterised encoder instantiated on next_b.
- All other logic lives in gray_counter: next-state mux, wrap detect, registers, reset synchroniser.

## Test plan
- Reset then count up:
  - Stimulus: WIDTH=4, en=1, up=1 for 17 cycles.
  - Required: g sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
  - wrap=1 only in the cycle after 1000→0000. Every step flips exactly one g bit.
- Count down from reset:
  - Stimulus: en=1, up=0.
  - Required: first step gives b=1111, g=1000, wrap=1. Next step gives b=1110, g=1001, wrap=0.
- Load:
  - Stimulus: load=1, bin_in=1010.
  - Required: next cycle b=1010, g=1111, wrap=0.
  - Stimulus: load=1 with en=1, up=1, bin_in=1111.
  - Required: b=1111, g=1000, no wrap. Load wins over en.
- Hold and direction change:
  - Stimulus: from b=0101, en=0 for 3 cycles.
  - Required: b and g unchanged (g=0111).
  - Stimulus: then up, up, down.
  - Required: b = 0110, 0111, 0110.
- Asynchronous reset mid-count:
  - Stimulus: drop rst_n between clock edges at b=1001.
  - Required: b=0, g=0, wrap=0 before the next edge.
  - Required: after release, no change until the second rising edge.
- Closed loop:
  - Stimulus: feed g into the Gray-to-binary decoder for 256 random en/up/load cycles.
  - Required: decoded value equals b on every cycle.
